opb_snapshot_bank_simulink2ppc: RTL and testbench
=================================================

# opb_snapshot_bank_simulink2ppc

Multi-channel successor to the single-word Simulink-to-PPC OPB register. It captures `C_NUM_CH` 32-bit user words into a coherent snapshot bank and exposes them, with control and status, as OPB slave registers. Two capture modes are supported: continuous (free-running latch) and armed one-shot. It sits on the OPB bus beside the other software registers, fed by fabric DSP outputs such as ADC power sums.

## Interface

**Parameters**
- `C_BASEADDR`, default `32'h01000700`: first byte address of the window.
- `C_HIGHADDR`, default `32'h010007FF`: last byte address of the window.
- `C_OPB_AWIDTH`, default 32: OPB address width.
- `C_OPB_DWIDTH`, default 32: OPB data width. Only 32 is supported.
- `C_NUM_CH`, default 4: number of snapshot channels, legal range 1..16.
- `C_FAMILY`, default `"virtex5"`: target family string.

**Ports**
- `OPB_Clk` in 1: the single clock. Bus and user data are both synchronous to it.
- `OPB_Rst` in 1: synchronous reset, **active-low**. Asserted when 0.
- `OPB_ABus` in [0:31]: address.
- `OPB_BE` in [0:3]: byte enables.
- `OPB_DBus` in [0:31]: write data.
- `OPB_RNW` in 1: 1 = read.
- `OPB_select` in 1: transfer request.
- `OPB_seqAddr` in 1: ignored.
- `Sl_DBus` out [0:31]: read data. Zero outside the ack cycle.
- `Sl_xferAck` out 1: transfer acknowledge.
- `Sl_errAck`, `Sl_retry`, `Sl_toutSup` out 1 each: always 0.
- `user_data_in` in `C_NUM_CH*32`: channel i occupies bits `[32*i+31:32*i]`.
- `user_valid` in 1: marks `user_data_in` valid this cycle.
- `snap_ready` out 1: mirrors STATUS.ready.

## Operation

**Register map** (byte offsets; bit 0 = LSB, numeric view):
- 0x00 CTRL (R/W; reset 0x4)
  - bit0 `arm`: self-clearing write strobe.
  - bit1 `clear`: self-clearing write strobe.
  - bit2 `cont`: sticky mode bit.
- 0x04 STATUS (RO; reset 0)
  - bit0 `ready`, bit1 `armed`.
  - bits[15:8] `overrun`: count of `user_valid` cycles seen while `ready`=1 in one-shot mode. Saturates at 0xFF. Cleared by arm or clear.
- 0x08 CAPCNT: see Configuration.
- 0x10 + 4·i: CH[i] snapshot (RO), for i < `C_NUM_CH`.

**Decode rules**
- Any other in-window offset reads 0; writes to it are ignored.
- Accesses outside `[C_BASEADDR, C_HIGHADDR]` are not acknowledged.
- A CTRL write takes effect only when `OPB_BE[3]` = 1 (the byte holding bits 7:0).

**Capture FSM** (active when `cont`=0)
- IDLE: write `arm` → ARMED.
- ARMED: first `user_valid` strictly after the write's ack cycle → latch all channels, go to READY.
- READY: write `arm` → ARMED (clears `ready`).
- Write `clear` in any state → IDLE; `ready`=0, `armed`=0, `overrun`=0. Channel contents are retained.
- A write with both `arm` and `clear` set: `clear` wins.

**Continuous mode** (`cont`=1)
- Every `user_valid` latches all channels and sets `ready`=1.
- FSM is held in IDLE; `arm` is ignored.
- Writing `cont`=0 leaves `ready` unchanged and enters IDLE.

**Coherency:** all channels always update in the same cycle.

## Timing

**Reset** (`OPB_Rst`=0 at a clock edge):
- All `Sl_*` outputs = 0.
- All CH = 0, STATUS = 0, CTRL = 0x4, CAPCNT = 0.
- FSM = IDLE.
- A transfer in flight is dropped without ack.

**Bus handshake**
- `OPB_select` and address hit at cycle t → `Sl_xferAck`=1 for exactly one cycle at t+1.
- Read data is valid on `Sl_DBus` only at t+1.
- Register writes take effect at t+1.
- Ack is not reissued while `OPB_select` is still high in the ack cycle. The next ack is at the earliest t+3.

**Capture latency**
- `user_valid` at cycle t → CH, `ready`, and CAPCNT updated at t+1.
- A read whose ack lands at t+1 returns the pre-capture value.

**Simultaneous events**
- CTRL `arm` write acked at t, with `user_valid` also at t: no capture; capture waits for the next `user_valid`.
- `clear` write acked in the same cycle as the ARMED capture: `clear` wins and there is no capture.

## Configuration

`SNAP_CAPCOUNT_EN`:
- **Defined:** a 32-bit CAPCNT at 0x08.
  - Increments on every latch.
  - Wraps 0xFFFFFFFF → 0.
  - Cleared by reset and by CTRL `clear`.
- **Undefined:** 0x08 reads 0, and no counter logic is built.

## Structure

- **Package `opb_snap_pkg`:**
  - register offsets
  - CTRL/STATUS bit indices
  - FSM state enum (IDLE, ARMED, READY)
  - `MAX_CH` = 16
- **Sub-module `opb_snap_slave_if`:**
  - window/address decode, one-shot ack generation, read-data mux gating
  - outputs: `rd_en`, `wr_en`, word offset, write data
- The top level holds the FSM, the channel registers, and CAPCNT.

## Test plan

- **Reset:** hold `OPB_Rst`=0 for 3 cycles, release → read CTRL = 0x4, STATUS = 0, CH0 = 0, and every ack is one cycle wide.
- **Continuous mode:** `user_data_in` ch0..3 = 0x11,0x22,0x33,0x44 with `user_valid` → reads return the same values and STATUS = 0x1.
- **One-shot:** write CTRL = 0x1 (with `OPB_BE`=0xF), drive `user_valid` with ch0 = 0xA5, then ch0 = 0x5A → CH0 = 0xA5, STATUS.ready = 1, overrun = 1.
- **Arm with valid in the ack cycle:** `user_valid` in the arm ack cycle → no capture until the next valid. Then `clear` together with the capture valid → STATUS = 0 and CH unchanged.
- **Decode:** read offset 0x0C and offset 0x10 + 4·`C_NUM_CH` → 0 with ack. Address `C_HIGHADDR`+4 → no ack, `Sl_DBus` = 0.
- **`SNAP_CAPCOUNT_EN` defined:** preload CAPCNT to 0xFFFFFFFF via force, one capture → 0. With the macro undefined, 0x08 reads 0.

Source files
------------

// File: rtl/opb_snap_pkg.sv
// Shared constants and types for the OPB snapshot bank: register word offsets,
// CTRL/STATUS bit positions and the one-shot capture state encoding.
package opb_snap_pkg;

    localparam int unsigned MAX_CH = 16;

    localparam int unsigned WORD_CTRL   = 0;
    localparam int unsigned WORD_STATUS = 1;
    localparam int unsigned WORD_CAPCNT = 2;
    localparam int unsigned WORD_CH0    = 4;

    localparam int unsigned CTRL_ARM   = 0;
    localparam int unsigned CTRL_CLEAR = 1;
    localparam int unsigned CTRL_CONT  = 2;

    // Byte lane carrying data bits 7:0 (OPB_BE[3] after numeric renumbering)
    localparam int unsigned BE_CTRL_LANE = 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_READY
    } snap_state_t;

endpackage

// File: rtl/opb_snap_slave_if.sv
// OPB slave front end: window decode, single-cycle ack, registered read data,
// and a write strobe issued in the ack cycle with the captured address/data.
module opb_snap_slave_if #(
    parameter int unsigned             AWIDTH   = 32,
    parameter logic [AWIDTH-1:0]       BASEADDR = 32'h01000700,
    parameter logic [AWIDTH-1:0]       HIGHADDR = 32'h010007FF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AWIDTH-1:0] abus,
    input  logic [3:0]        be,
    input  logic [31:0]       dbus,
    input  logic              rnw,
    input  logic              select,
    input  logic [31:0]       rd_data,
    output logic              rd_en,
    output logic [AWIDTH-3:0] rd_word,
    output logic              wr_en,
    output logic [AWIDTH-3:0] wr_word,
    output logic [31:0]       wr_data,
    output logic [3:0]        wr_be,
    output logic [31:0]       sl_dbus,
    output logic              xfer_ack
);

    logic              ack_q;
    logic              rnw_q;
    logic [31:0]       rd_q;
    logic [AWIDTH-1:0] ofs;
    logic              hit;
    logic              req;

    assign hit     = select && (abus >= BASEADDR) && (abus <= HIGHADDR);
    // A request still held in its own ack cycle must not be acknowledged twice
    assign req     = hit && !ack_q;
    assign ofs     = abus - BASEADDR;
    assign rd_word = ofs[AWIDTH-1:2];
    assign rd_en   = req && rnw;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_q   <= 1'b0;
            rnw_q   <= 1'b0;
            wr_word <= '0;
            wr_data <= '0;
            wr_be   <= '0;
            rd_q    <= '0;
        end else begin
            ack_q <= req;
            rd_q  <= rd_en ? rd_data : '0;
            if (req) begin
                rnw_q   <= rnw;
                wr_word <= rd_word;
                wr_data <= dbus;
                wr_be   <= be;
            end
        end
    end

    assign wr_en    = ack_q && !rnw_q;
    assign xfer_ack = ack_q;
    assign sl_dbus  = ack_q ? rd_q : '0;

endmodule

// File: rtl/opb_snapshot_bank_simulink2ppc.sv
// Coherent multi-channel snapshot bank on OPB with continuous and armed one-shot capture.
// Optional 32-bit capture counter at 0x08 when SNAP_CAPCOUNT_EN is defined.
module opb_snapshot_bank_simulink2ppc
    import opb_snap_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01000700,
    parameter logic [31:0] C_HIGHADDR   = 32'h010007FF,
    parameter int unsigned C_OPB_AWIDTH = 32,
    parameter int unsigned C_OPB_DWIDTH = 32,
    parameter int unsigned C_NUM_CH     = 4,
    parameter string       C_FAMILY     = "virtex5"
) (
    input  logic                     OPB_Clk,
    input  logic                     OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]  OPB_ABus,
    input  logic [0:3]               OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]  OPB_DBus,
    input  logic                     OPB_RNW,
    input  logic                     OPB_select,
    input  logic                     OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]  Sl_DBus,
    output logic                     Sl_xferAck,
    output logic                     Sl_errAck,
    output logic                     Sl_retry,
    output logic                     Sl_toutSup,
    input  logic [C_NUM_CH*32-1:0]   user_data_in,
    input  logic                     user_valid,
    output logic                     snap_ready
);

    localparam int unsigned WW = C_OPB_AWIDTH - 2;

    logic          rd_en;
    logic [WW-1:0] rd_word;
    logic          wr_en;
    logic [WW-1:0] wr_word;
    logic [31:0]   wr_data;
    logic [3:0]    wr_be;
    logic [31:0]   rd_mux;
    logic [31:0]   sl_dbus;

    snap_state_t   state;
    logic          cont;
    logic          ready;
    logic [7:0]    overrun;
    logic [31:0]   ch_q [C_NUM_CH];

    logic ctrl_wr, do_clear, do_arm, cont_next, capture, ovr_hit;
    logic unused_bits;

    opb_snap_slave_if #(
        .AWIDTH   (C_OPB_AWIDTH),
        .BASEADDR (C_BASEADDR),
        .HIGHADDR (C_HIGHADDR)
    ) u_if (
        .clk      (OPB_Clk),
        .rst_n    (OPB_Rst),
        .abus     (OPB_ABus),
        .be       (OPB_BE),
        .dbus     (OPB_DBus),
        .rnw      (OPB_RNW),
        .select   (OPB_select),
        .rd_data  (rd_mux),
        .rd_en    (rd_en),
        .rd_word  (rd_word),
        .wr_en    (wr_en),
        .wr_word  (wr_word),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .sl_dbus  (sl_dbus),
        .xfer_ack (Sl_xferAck)
    );

    assign Sl_DBus    = sl_dbus;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign snap_ready = ready;

    assign unused_bits = ^{OPB_seqAddr, wr_data[31:3], wr_be[3:1]};

    // Arm only counts when the same write leaves continuous mode off; clear overrides arm.
    assign ctrl_wr   = wr_en && (wr_word == WW'(WORD_CTRL)) && wr_be[BE_CTRL_LANE];
    assign do_clear  = ctrl_wr && wr_data[CTRL_CLEAR];
    assign do_arm    = ctrl_wr && wr_data[CTRL_ARM] && !wr_data[CTRL_CLEAR] && !wr_data[CTRL_CONT];
    assign cont_next = ctrl_wr ? wr_data[CTRL_CONT] : cont;
    assign capture   = user_valid && !do_clear && !do_arm && (cont || (state == S_ARMED));
    assign ovr_hit   = user_valid && ready && !cont && !do_clear && !do_arm;

`ifdef SNAP_CAPCOUNT_EN
    logic [31:0] capcnt;

    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst || do_clear) begin
            capcnt <= '0;
        end else if (capture) begin
            capcnt <= capcnt + 32'd1;
        end
    end
`else
    logic [31:0] capcnt;
    assign capcnt = '0;
`endif

    always_comb begin
        rd_mux = '0;
        if (rd_en) begin
            if (rd_word == WW'(WORD_CTRL)) begin
                rd_mux = {29'h0, cont, 2'b00};
            end else if (rd_word == WW'(WORD_STATUS)) begin
                rd_mux = {16'h0, overrun, 6'h0, state == S_ARMED, ready};
            end else if (rd_word == WW'(WORD_CAPCNT)) begin
                rd_mux = capcnt;
            end
            for (int unsigned i = 0; i < C_NUM_CH; i++) begin
                if (rd_word == WW'(WORD_CH0 + i)) begin
                    rd_mux = ch_q[i];
                end
            end
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst) begin
            state   <= S_IDLE;
            cont    <= 1'b1;
            ready   <= 1'b0;
            overrun <= '0;
            for (int unsigned i = 0; i < C_NUM_CH; i++) begin
                ch_q[i] <= '0;
            end
        end else begin
            cont <= cont_next;

            if (cont_next || do_clear) begin
                state <= S_IDLE;
            end else if (do_arm) begin
                state <= S_ARMED;
            end else if (capture) begin
                state <= S_READY;
            end

            if (do_clear || do_arm) begin
                ready <= 1'b0;
            end else if (capture) begin
                ready <= 1'b1;
            end

            if (do_clear || do_arm) begin
                overrun <= '0;
            end else if (ovr_hit && (overrun != 8'hFF)) begin
                overrun <= overrun + 8'd1;
            end

            if (capture) begin
                for (int unsigned i = 0; i < C_NUM_CH; i++) begin
                    ch_q[i] <= user_data_in[32*i +: 32];
                end
            end
        end
    end

endmodule

// File: tb/tb_opb_snapshot_bank_simulink2ppc.sv
// Directed bench for opb_snapshot_bank_simulink2ppc (default 4 channels).
// Exercises CAPCNT wrap when SNAP_CAPCOUNT_EN is defined, otherwise checks 0x08 reads 0.
module tb_opb_snapshot_bank_simulink2ppc;

    localparam logic [31:0] BASE = 32'h01000700;
    localparam logic [31:0] HIGH = 32'h010007FF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [0:31]   abus = '0;
    logic [0:3]    be = '0;
    logic [0:31]   dbus = '0;
    logic          rnw = 1'b0;
    logic          sel = 1'b0;
    logic          seq = 1'b0;
    logic [0:31]   sl_dbus;
    logic          sl_ack, sl_err, sl_retry, sl_tout;
    logic [127:0]  ud = '0;
    logic          uvalid = 1'b0;
    logic          snap_ready;

    int total = 0;
    int bad = 0;

    opb_snapshot_bank_simulink2ppc dut (
        .OPB_Clk      (clk),
        .OPB_Rst      (rst_n),
        .OPB_ABus     (abus),
        .OPB_BE       (be),
        .OPB_DBus     (dbus),
        .OPB_RNW      (rnw),
        .OPB_select   (sel),
        .OPB_seqAddr  (seq),
        .Sl_DBus      (sl_dbus),
        .Sl_xferAck   (sl_ack),
        .Sl_errAck    (sl_err),
        .Sl_retry     (sl_retry),
        .Sl_toutSup   (sl_tout),
        .user_data_in (ud),
        .user_valid   (uvalid),
        .snap_ready   (snap_ready)
    );

    always #5 clk = ~clk;

    task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data, output logic ack);
        @(negedge clk);
        sel = 1'b1; rnw = 1'b1; abus = addr; be = 4'hF;
        @(negedge clk);
        data = sl_dbus; ack = sl_ack;
        sel = 1'b0; rnw = 1'b0; abus = '0;
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] lanes,
                          input logic vld_in_ack, input logic [31:0] ch0_in_ack, output logic ack);
        @(negedge clk);
        sel = 1'b1; rnw = 1'b0; abus = addr; dbus = data; be = lanes;
        @(negedge clk);
        ack = sl_ack;
        sel = 1'b0; abus = '0; dbus = '0;
        if (vld_in_ack) begin
            ud = {96'h0, ch0_in_ack};
            uvalid = 1'b1;
            @(negedge clk);
            uvalid = 1'b0;
        end
    endtask

    task automatic pulse_valid(input logic [127:0] d);
        @(negedge clk);
        ud = d; uvalid = 1'b1;
        @(negedge clk);
        uvalid = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic a;
        sel = 1'b1; rnw = 1'b1; abus = BASE; be = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (sl_ack !== 1'b0 || sl_dbus !== 32'h0 || sl_err !== 1'b0 || sl_retry !== 1'b0 || sl_tout !== 1'b0) begin
                $display("FAIL reset_outputs ack=%b dbus=%h err=%b retry=%b tout=%b want all 0",
                         sl_ack, sl_dbus, sl_err, sl_retry, sl_tout);
                bad++;
            end
        end
        sel = 1'b0; rnw = 1'b0;
        rst_n = 1'b1;
        // Held read of CTRL: ack one cycle wide, then silent while select stays high
        @(negedge clk);
        sel = 1'b1; rnw = 1'b1; abus = BASE;
        @(negedge clk);
        total++;
        if (sl_ack !== 1'b1 || sl_dbus !== 32'h4) begin
            $display("FAIL reset_ctrl ack=%b data=%h want ack=1 data=00000004", sl_ack, sl_dbus);
            bad++;
        end
        @(negedge clk);
        total++;
        if (sl_ack !== 1'b0 || sl_dbus !== 32'h0) begin
            $display("FAIL ack_width ack=%b data=%h want ack=0 data=0", sl_ack, sl_dbus);
            bad++;
        end
        @(negedge clk);
        total++;
        if (sl_ack !== 1'b1) begin
            $display("FAIL ack_reissue_t3 ack=%b want 1", sl_ack);
            bad++;
        end
        sel = 1'b0; rnw = 1'b0; abus = '0;
        bus_rd(BASE + 32'h04, d, a);
        total++;
        if (a !== 1'b1 || d !== 32'h0) begin
            $display("FAIL reset_status ack=%b data=%h want ack=1 data=0", a, d);
            bad++;
        end
        bus_rd(BASE + 32'h10, d, a);
        total++;
        if (a !== 1'b1 || d !== 32'h0 || snap_ready !== 1'b0) begin
            $display("FAIL reset_ch0 ack=%b data=%h ready=%b want ack=1 data=0 ready=0", a, d, snap_ready);
            bad++;
        end
    endtask

    task automatic test_continuous;
        logic [31:0] d;
        logic [31:0] exp_ch [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        logic a;
        pulse_valid({32'h44, 32'h33, 32'h22, 32'h11});
        for (int i = 0; i < 4; i++) begin
            bus_rd(BASE + 32'h10 + 32'(4 * i), d, a);
            total++;
            if (a !== 1'b1 || d !== exp_ch[i]) begin
                $display("FAIL cont_ch%0d ack=%b data=%h want %h", i, a, d, exp_ch[i]);
                bad++;
            end
        end
        bus_rd(BASE + 32'h04, d, a);
        total++;
        if (d !== 32'h1 || snap_ready !== 1'b1) begin
            $display("FAIL cont_status data=%h ready=%b want 00000001 ready=1", d, snap_ready);
            bad++;
        end
        // Read requested in the same cycle as a capture returns the old value
        @(negedge clk);
        sel = 1'b1; rnw = 1'b1; abus = BASE + 32'h10; be = 4'hF;
        ud = {96'h0, 32'h55}; uvalid = 1'b1;
        @(negedge clk);
        total++;
        if (sl_ack !== 1'b1 || sl_dbus !== 32'h11) begin
            $display("FAIL cont_latency ack=%b data=%h want 00000011", sl_ack, sl_dbus);
            bad++;
        end
        sel = 1'b0; rnw = 1'b0; uvalid = 1'b0;
        bus_rd(BASE + 32'h10, d, a);
        total++;
        if (d !== 32'h55) begin
            $display("FAIL cont_after_latency data=%h want 00000055", d);
            bad++;
        end
    endtask

    task automatic test_oneshot;
        logic [31:0] d;
        logic a;
        bus_wr(BASE, 32'h1, 4'hF, 1'b0, 32'h0, a);
        total++;
        if (a !== 1'b1) begin
            $display("FAIL arm_ack ack=%b want 1", a);
            bad++;
        end
        bus_rd(BASE + 32'h04, d, a);
        total++;
        if (d !== 32'h2) begin
            $display("FAIL armed_status data=%h want 00000002", d);
            bad++;
        end
        pulse_valid({96'h0, 32'hA5});
        pulse_valid({96'h0, 32'h5A});
        bus_rd(BASE + 32'h10, d, a);
        total++;
        if (d !== 32'hA5) begin
            $display("FAIL oneshot_ch0 data=%h want 000000a5", d);
            bad++;
        end
        bus_rd(BASE + 32'h04, d, a);
        total++;
        if (d !== 32'h101) begin
            $display("FAIL oneshot_status data=%h want 00000101", d);
            bad++;
        end
    endtask

    task automatic test_arm_in_ack;
        logic [31:0] d;
        logic a;
        bus_wr(BASE, 32'h1, 4'hF, 1'b1, 32'h77, a);
        bus_rd(BASE + 32'h10, d, a);
        total++;
        if (d !== 32'hA5) begin
            $display("FAIL arm_ack_nocap data=%h want 000000a5", d);
            bad++;
        end
        bus_rd(BASE + 32'h04, d, a);
        total++;
        if (d !== 32'h2) begin
            $display("FAIL arm_ack_status data=%h want 00000002", d);
            bad++;
        end
        pulse_valid({96'h0, 32'h66});
        bus_rd(BASE + 32'h10, d, a);
        total++;
        if (d !== 32'h66) begin
            $display("FAIL arm_next_cap data=%h want 00000066", d);
            bad++;
        end
        bus_wr(BASE, 32'h1, 4'hF, 1'b0, 32'h0, a);
        bus_wr(BASE, 32'h2, 4'hF, 1'b1, 32'h99, a);
        bus_rd(BASE + 32'h04, d, a);
        total++;
        if (d !== 32'h0) begin
            $display("FAIL clear_wins_status data=%h want 0", d);
            bad++;
        end
        bus_rd(BASE + 32'h10, d, a);
        total++;
        if (d !== 32'h66) begin
            $display("FAIL clear_wins_ch0 data=%h want 00000066", d);
            bad++;
        end
        // arm and clear together: clear wins, so the next valid is not captured
        bus_wr(BASE, 32'h3, 4'hF, 1'b0, 32'h0, a);
        pulse_valid({96'h0, 32'h12});
        bus_rd(BASE + 32'h10, d, a);
        total++;
        if (d !== 32'h66) begin
            $display("FAIL arm_clear_ch0 data=%h want 00000066", d);
            bad++;
        end
    endtask

    task automatic test_overrun_sat;
        logic [31:0] d;
        logic a;
        bus_wr(BASE, 32'h1, 4'hF, 1'b0, 32'h0, a);
        for (int i = 0; i < 300; i++) begin
            pulse_valid({96'h0, 32'(i)});
        end
        bus_rd(BASE + 32'h04, d, a);
        total++;
        if (d !== 32'hFF01) begin
            $display("FAIL overrun_sat data=%h want 0000ff01", d);
            bad++;
        end
        bus_rd(BASE + 32'h10, d, a);
        total++;
        if (d !== 32'h0) begin
            $display("FAIL overrun_first_cap data=%h want 0", d);
            bad++;
        end
        bus_wr(BASE, 32'h2, 4'hF, 1'b0, 32'h0, a);
        bus_rd(BASE + 32'h04, d, a);
        total++;
        if (d !== 32'h0) begin
            $display("FAIL clear_status data=%h want 0", d);
            bad++;
        end
    endtask

    task automatic test_decode;
        logic [31:0] d;
        logic a;
        bus_rd(BASE + 32'h0C, d, a);
        total++;
        if (a !== 1'b1 || d !== 32'h0) begin
            $display("FAIL hole_0c ack=%b data=%h want ack=1 data=0", a, d);
            bad++;
        end
        bus_rd(BASE + 32'h20, d, a);
        total++;
        if (a !== 1'b1 || d !== 32'h0) begin
            $display("FAIL past_ch ack=%b data=%h want ack=1 data=0", a, d);
            bad++;
        end
        bus_rd(HIGH + 32'h4, d, a);
        total++;
        if (a !== 1'b0 || d !== 32'h0) begin
            $display("FAIL out_of_window ack=%b data=%h want ack=0 data=0", a, d);
            bad++;
        end
        bus_wr(BASE, 32'h4, 4'hE, 1'b0, 32'h0, a);
        bus_rd(BASE, d, a);
        total++;
        if (d !== 32'h0) begin
            $display("FAIL ctrl_be_masked data=%h want 0", d);
            bad++;
        end
        bus_wr(BASE, 32'h4, 4'hF, 1'b0, 32'h0, a);
        bus_rd(BASE, d, a);
        total++;
        if (d !== 32'h4) begin
            $display("FAIL ctrl_cont_set data=%h want 00000004", d);
            bad++;
        end
    endtask

    task automatic test_capcnt;
        logic [31:0] d;
        logic a;
`ifdef SNAP_CAPCOUNT_EN
        @(negedge clk);
        force dut.capcnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.capcnt;
        pulse_valid({96'h0, 32'hC0});
        bus_rd(BASE + 32'h08, d, a);
        total++;
        if (d !== 32'h0) begin
            $display("FAIL capcnt_wrap data=%h want 0", d);
            bad++;
        end
        pulse_valid({96'h0, 32'hC1});
        bus_rd(BASE + 32'h08, d, a);
        total++;
        if (d !== 32'h1) begin
            $display("FAIL capcnt_inc data=%h want 00000001", d);
            bad++;
        end
`else
        pulse_valid({96'h0, 32'hC0});
        bus_rd(BASE + 32'h08, d, a);
        total++;
        if (a !== 1'b1 || d !== 32'h0) begin
            $display("FAIL capcnt_absent ack=%b data=%h want ack=1 data=0", a, d);
            bad++;
        end
`endif
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_oneshot();
        test_arm_in_ack();
        test_overrun_sat();
        test_decode();
        test_capcnt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
